tictactoe_move_sequencer: RTL

- Owns the 3x3 game board and shares write access to it between two requesters: the player move path and the computer move path.
- Arbitrates simultaneous requests and rejects illegal moves.
- After each accepted move, runs a fixed-latency multi-cycle win / no-space evaluation.
- Produces the illegal_move, win and no_space status consumed by the game FSM controller.

---
 rtl/tictactoe_pkg.sv | 70 +++++++
 rtl/tictactoe_line_check.sv | 15 +
 rtl/tictactoe_move_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/tictactoe_pkg.sv
// Shared types for the tic-tac-toe move sequencer: cell codes, FSM states,
// the winning-line table and small board access helpers.
package tictactoe_pkg;

    localparam int NUM_CELLS = 9;
    localparam int NUM_LINES = 8;
    localparam int BOARD_W   = 2 * NUM_CELLS;

    typedef logic [1:0]         cell_t;
    typedef logic [3:0]         cell_idx_t;
    typedef logic [BOARD_W-1:0] board_t;

    localparam cell_t EMPTY    = 2'b00;
    localparam cell_t PLAYER   = 2'b01;
    localparam cell_t COMPUTER = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        EVAL,
        REPORT,
        GAME_OVER
    } state_t;

    // Scan order matters: the first matching line decides the reported owner.
    localparam cell_idx_t WIN_LINES [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    function automatic cell_t cell_at(input board_t b, input cell_idx_t idx);
        cell_t c;
        c = EMPTY;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (idx == cell_idx_t'(i)) begin
                c = b[2*i +: 2];
            end
        end
        return c;
    endfunction

    function automatic board_t set_cell(input board_t b, input cell_idx_t idx, input cell_t v);
        board_t r;
        r = b;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (idx == cell_idx_t'(i)) begin
                r[2*i +: 2] = v;
            end
        end
        return r;
    endfunction

    function automatic logic board_full(input board_t b);
        logic full;
        full = 1'b1;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (b[2*i +: 2] == EMPTY) begin
                full = 1'b0;
            end
        end
        return full;
    endfunction

endpackage

// File: rtl/tictactoe_line_check.sv
// Combinational check of one winning line: all three cells equal and occupied.
module tictactoe_line_check
    import tictactoe_pkg::*;
(
    input  cell_t cell_a,
    input  cell_t cell_b,
    input  cell_t cell_c,
    output logic  match,
    output cell_t owner
);

    assign match = (cell_a != EMPTY) && (cell_a == cell_b) && (cell_b == cell_c);
    assign owner = match ? cell_a : EMPTY;

endmodule

// File: rtl/tictactoe_move_sequencer.sv
// Board owner for the tic-tac-toe game: arbitrates player/computer moves,
// rejects illegal ones and runs a fixed 8-cycle win / full-board evaluation.
module tictactoe_move_sequencer
    import tictactoe_pkg::*;
#(
    parameter bit FIRST_PRIO = 1'b0,
    parameter int LINES      = NUM_LINES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        player_req,
    input  logic [3:0]  player_pos,
    input  logic        pc_req,
    input  logic [3:0]  pc_pos,
    output logic        player_ack,
    output logic        pc_ack,
    output logic        illegal_move,
    output logic [17:0] board,
    output logic        busy,
    output logic        done,
    output logic        win,
    output logic [1:0]  winner,
    output logic        no_space
);

    state_t    state_q, state_d;
    board_t    board_q, board_d;
    logic      prio_q, prio_d;       // 1: computer favoured on a tie
    logic      src_q, src_d;         // 1: move in flight belongs to the computer
    cell_idx_t pos_q, pos_d;
    logic [2:0] line_q, line_d;
    logic      flag_q, flag_d;
    cell_t     owner_q, owner_d;
    logic      player_ack_q, player_ack_d;
    logic      pc_ack_q, pc_ack_d;
    logic      illegal_q, illegal_d;
    logic      done_q, done_d;
    logic      win_q, win_d;
    cell_t     winner_q, winner_d;
    logic      no_space_q, no_space_d;

    logic      grant_pc;
    logic      move_legal;
    logic      is_full;
    cell_t     lc_a, lc_b, lc_c;
    logic      lc_match;
    cell_t     lc_owner;

    assign lc_a    = cell_at(board_q, WIN_LINES[line_q][0]);
    assign lc_b    = cell_at(board_q, WIN_LINES[line_q][1]);
    assign lc_c    = cell_at(board_q, WIN_LINES[line_q][2]);
    assign is_full = board_full(board_q);

    tictactoe_line_check u_line_check (
        .cell_a (lc_a),
        .cell_b (lc_b),
        .cell_c (lc_c),
        .match  (lc_match),
        .owner  (lc_owner)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        prio_d       = prio_q;
        src_d        = src_q;
        pos_d        = pos_q;
        line_d       = line_q;
        flag_d       = flag_q;
        owner_d      = owner_q;
        player_ack_d = 1'b0;
        pc_ack_d     = 1'b0;
        illegal_d    = 1'b0;
        done_d       = 1'b0;
        win_d        = win_q;
        winner_d     = winner_q;
        no_space_d   = no_space_q;
        grant_pc     = 1'b0;
        move_legal   = 1'b0;

        case (state_q)
            IDLE: begin
                if (player_req || pc_req) begin
                    grant_pc = pc_req && (!player_req || prio_q);
                    src_d    = grant_pc;
                    pos_d    = grant_pc ? pc_pos : player_pos;
                    prio_d   = !grant_pc;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                move_legal   = (pos_q <= 4'd8) && (cell_at(board_q, pos_q) == EMPTY);
                player_ack_d = !src_q;
                pc_ack_d     = src_q;
                if (move_legal) begin
                    board_d = set_cell(board_q, pos_q, src_q ? COMPUTER : PLAYER);
                    line_d  = '0;
                    flag_d  = 1'b0;
                    owner_d = EMPTY;
                    state_d = EVAL;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            EVAL: begin
                if (lc_match && !flag_q) begin
                    flag_d  = 1'b1;
                    owner_d = lc_owner;
                end
                // Always scan every line so the report latency never varies.
                if (line_q == 3'(LINES - 1)) begin
                    state_d = REPORT;
                end else begin
                    line_d = line_q + 3'd1;
                end
            end
            REPORT: begin
                win_d      = flag_q;
                winner_d   = owner_q;
                no_space_d = is_full && !flag_q;
                done_d     = 1'b1;
                state_d    = (flag_q || is_full) ? GAME_OVER : IDLE;
            end
            GAME_OVER: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // New game: identical to reset, abandoning any move in flight.
        if (clear) begin
            state_d      = IDLE;
            board_d      = '0;
            prio_d       = FIRST_PRIO;
            src_d        = 1'b0;
            pos_d        = '0;
            line_d       = '0;
            flag_d       = 1'b0;
            owner_d      = EMPTY;
            player_ack_d = 1'b0;
            pc_ack_d     = 1'b0;
            illegal_d    = 1'b0;
            done_d       = 1'b0;
            win_d        = 1'b0;
            winner_d     = EMPTY;
            no_space_d   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            board_q      <= '0;
            prio_q       <= FIRST_PRIO;
            src_q        <= 1'b0;
            pos_q        <= '0;
            line_q       <= '0;
            flag_q       <= 1'b0;
            owner_q      <= EMPTY;
            player_ack_q <= 1'b0;
            pc_ack_q     <= 1'b0;
            illegal_q    <= 1'b0;
            done_q       <= 1'b0;
            win_q        <= 1'b0;
            winner_q     <= EMPTY;
            no_space_q   <= 1'b0;
        end else begin
            board_q      <= board_d;
            prio_q       <= prio_d;
            src_q        <= src_d;
            pos_q        <= pos_d;
            line_q       <= line_d;
            flag_q       <= flag_d;
            owner_q      <= owner_d;
            player_ack_q <= player_ack_d;
            pc_ack_q     <= pc_ack_d;
            illegal_q    <= illegal_d;
            done_q       <= done_d;
            win_q        <= win_d;
            winner_q     <= winner_d;
            no_space_q   <= no_space_d;
        end
    end

    assign board        = board_q;
    assign player_ack   = player_ack_q;
    assign pc_ack       = pc_ack_q;
    assign illegal_move = illegal_q;
    assign done         = done_q;
    assign win          = win_q;
    assign winner       = winner_q;
    assign no_space     = no_space_q;
    assign busy         = (state_q == CHECK) || (state_q == EVAL) || (state_q == REPORT);

endmodule
